// File: rtl/nibble_serial_adder_seq_if.sv
// rtl/nibble_serial_adder_seq_if.sv - operand, result and external-adder signal bundle
interface nibble_serial_adder_seq_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;

    logic [3:0]   add_a;
    logic [3:0]   add_b;
    logic         add_cin;
    logic [3:0]   add_sum;
    logic         add_cout;

    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;

    logic         busy;

    modport master (
        output in_valid, in_a, in_b, in_cin, out_ready, add_sum, add_cout,
        input  in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_cout, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, out_ready, add_sum, add_cout,
        output in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_cout, busy
    );
endinterface

// File: rtl/nibble_serial_adder_seq.sv
// rtl/nibble_serial_adder_seq.sv - wide adder driving an external 4-bit adder one nibble per cycle
module nibble_serial_adder_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    nibble_serial_adder_seq_if.slave bus
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic [W-1:0]  sum_reg;
    logic          carry_reg;
    logic [IW-1:0] idx;
    logic          load;
    logic          step;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state    = state;
        load          = 1'b0;
        step          = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_sum   = '0;
        bus.out_cout  = 1'b0;
        bus.busy      = 1'b0;
        bus.add_a     = 4'h0;
        bus.add_b     = 4'h0;
        bus.add_cin   = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    load       = 1'b1;
                    next_state = RUN;
                end
            end
            RUN: begin
                bus.busy    = 1'b1;
                step        = 1'b1;
                bus.add_a   = a_reg[4*idx +: 4];
                bus.add_b   = b_reg[4*idx +: 4];
                bus.add_cin = carry_reg;
                if (idx == LAST) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                bus.busy      = 1'b1;
                bus.out_valid = 1'b1;
                bus.out_sum   = sum_reg;
                bus.out_cout  = carry_reg;
                if (bus.out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // The adder result is captured straight from the combinational external path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            idx       <= '0;
        end else if (load) begin
            a_reg     <= bus.in_a;
            b_reg     <= bus.in_b;
            sum_reg   <= '0;
            carry_reg <= bus.in_cin;
            idx       <= '0;
        end else if (step) begin
            sum_reg[4*idx +: 4] <= bus.add_sum;
            carry_reg           <= bus.add_cout;
            if (idx != LAST) begin
                idx <= idx + IW'(1);
            end
        end
    end
endmodule

// File: tb/tb_nibble_serial_adder_seq.sv
// tb/tb_nibble_serial_adder_seq.sv - directed vector bench for nibble_serial_adder_seq
module tb_nibble_serial_adder_seq;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    nibble_serial_adder_seq_if #(.NIBBLES(4)) if4 ();
    nibble_serial_adder_seq_if #(.NIBBLES(1)) if1 ();

    nibble_serial_adder_seq #(.NIBBLES(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
    nibble_serial_adder_seq #(.NIBBLES(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

    // Behavioural stand-in for the external 4-bit ripple-carry adder
    assign {if4.add_cout, if4.add_sum} = {1'b0, if4.add_a} + {1'b0, if4.add_b} + {4'h0, if4.add_cin};
    assign {if1.add_cout, if1.add_sum} = {1'b0, if1.add_a} + {1'b0, if1.add_b} + {4'h0, if1.add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic wait_out4(output int cyc);
        cyc = 0;
        while (!if4.out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic run4(input logic [15:0] a, input logic [15:0] b, input logic cin,
                        input logic [15:0] es, input logic ec, input string tag);
        int cyc;
        cyc = 0;
        while (!if4.in_ready && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, " in_ready idle"}, 32'(if4.in_ready), 32'd1);
        if4.in_a     = a;
        if4.in_b     = b;
        if4.in_cin   = cin;
        if4.in_valid = 1'b1;
        @(negedge clk);
        if4.in_valid = 1'b0;
        wait_out4(cyc);
        chk({tag, " latency"}, 32'(cyc), 32'd4);
        chk({tag, " out_valid"}, 32'(if4.out_valid), 32'd1);
        chk({tag, " out_sum"}, 32'(if4.out_sum), 32'(es));
        chk({tag, " out_cout"}, 32'(if4.out_cout), 32'(ec));
        chk({tag, " in_ready done"}, 32'(if4.in_ready), 32'd0);
        if4.out_ready = 1'b1;
        @(negedge clk);
        if4.out_ready = 1'b0;
        chk({tag, " in_ready after"}, 32'(if4.in_ready), 32'd1);
        chk({tag, " out_sum idle"}, 32'(if4.out_sum), 32'd0);
    endtask

    initial begin
        int cyc;
        logic [15:0] na;
        logic [15:0] nb;
        n_checks = 0;
        n_fail   = 0;
        vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
        vecs[1] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0};
        vecs[2] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        vecs[4] = '{16'h0F0F, 16'hF0F0, 1'b1, 16'h0000, 1'b1};
        vecs[5] = '{16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0};
        vecs[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};

        rst = 1'b1;
        {if4.in_valid, if4.in_cin, if4.out_ready} = 3'b100;
        if4.in_a = 16'h1111;
        if4.in_b = 16'h2222;
        {if1.in_valid, if1.in_cin, if1.out_ready} = 3'b000;
        if1.in_a = 4'h0;
        if1.in_b = 4'h0;
        repeat (2) @(negedge clk);
        chk("reset in_ready", 32'(if4.in_ready), 32'd1);
        chk("reset out_valid", 32'(if4.out_valid), 32'd0);
        chk("reset busy", 32'(if4.busy), 32'd0);
        chk("reset add", {23'd0, if4.add_a, if4.add_b, if4.add_cin}, 32'd0);
        chk("reset out_sum", {15'd0, if4.out_cout, if4.out_sum}, 32'd0);
        if4.in_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run4(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout, $sformatf("vec%0d", i));
        end

        // add_a/add_b/add_cin walk LSB nibble first
        na = 16'h1234;
        nb = 16'h4321;
        if4.in_a = na;
        if4.in_b = nb;
        if4.in_cin = 1'b1;
        if4.in_valid = 1'b1;
        @(negedge clk);
        if4.in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("seq add_a[%0d]", k), 32'(if4.add_a), 32'(na[4*k +: 4]));
            chk($sformatf("seq add_b[%0d]", k), 32'(if4.add_b), 32'(nb[4*k +: 4]));
            chk($sformatf("seq add_cin[%0d]", k), 32'(if4.add_cin), (k == 0) ? 32'd1 : 32'd0);
            chk($sformatf("seq busy[%0d]", k), 32'(if4.busy), 32'd1);
            @(negedge clk);
        end
        chk("seq out_valid", 32'(if4.out_valid), 32'd1);
        chk("seq out_sum", 32'(if4.out_sum), 32'h5556);
        chk("seq add idle", {27'd0, if4.add_a, if4.add_cin}, 32'd0);
        if4.out_ready = 1'b1;
        @(negedge clk);
        if4.out_ready = 1'b0;

        // backpressure
        if4.in_a = 16'h000F;
        if4.in_b = 16'h0001;
        if4.in_cin = 1'b0;
        if4.in_valid = 1'b1;
        @(negedge clk);
        if4.in_valid = 1'b0;
        wait_out4(cyc);
        chk("bp latency", 32'(cyc), 32'd4);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("bp out_valid[%0d]", k), 32'(if4.out_valid), 32'd1);
            chk($sformatf("bp out_sum[%0d]", k), 32'(if4.out_sum), 32'h0010);
            chk($sformatf("bp out_cout[%0d]", k), 32'(if4.out_cout), 32'd0);
            chk($sformatf("bp in_ready[%0d]", k), 32'(if4.in_ready), 32'd0);
            @(negedge clk);
        end
        if4.out_ready = 1'b1;
        @(negedge clk);
        if4.out_ready = 1'b0;
        chk("bp in_ready after", 32'(if4.in_ready), 32'd1);
        chk("bp out_valid after", 32'(if4.out_valid), 32'd0);

        // request during RUN is ignored until in_ready returns
        if4.in_a = 16'h0001;
        if4.in_b = 16'h0001;
        if4.in_valid = 1'b1;
        @(negedge clk);
        if4.in_a = 16'hAAAA;
        if4.in_b = 16'h5555;
        chk("ign in_ready run", 32'(if4.in_ready), 32'd0);
        wait_out4(cyc);
        chk("ign latency", 32'(cyc), 32'd4);
        chk("ign out_sum", 32'(if4.out_sum), 32'h0002);
        chk("ign out_cout", 32'(if4.out_cout), 32'd0);
        if4.out_ready = 1'b1;
        @(negedge clk);
        if4.out_ready = 1'b0;
        chk("ign in_ready", 32'(if4.in_ready), 32'd1);
        @(negedge clk);
        if4.in_valid = 1'b0;
        chk("ign second busy", 32'(if4.busy), 32'd1);
        wait_out4(cyc);
        chk("ign second latency", 32'(cyc), 32'd4);
        chk("ign second out_sum", 32'(if4.out_sum), 32'hFFFF);
        chk("ign second out_cout", 32'(if4.out_cout), 32'd0);
        if4.out_ready = 1'b1;
        @(negedge clk);
        if4.out_ready = 1'b0;

        // reset after two RUN cycles
        if4.in_a = 16'h1234;
        if4.in_b = 16'h1111;
        if4.in_valid = 1'b1;
        @(negedge clk);
        if4.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst out_valid", 32'(if4.out_valid), 32'd0);
        chk("rst in_ready", 32'(if4.in_ready), 32'd1);
        chk("rst busy", 32'(if4.busy), 32'd0);
        chk("rst add", {23'd0, if4.add_a, if4.add_b, if4.add_cin}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run4(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, "post rst");

        // single-nibble instance
        if1.in_a = 4'hF;
        if1.in_b = 4'hF;
        if1.in_cin = 1'b1;
        if1.in_valid = 1'b1;
        chk("n1 in_ready", 32'(if1.in_ready), 32'd1);
        @(negedge clk);
        if1.in_valid = 1'b0;
        chk("n1 add_a", 32'(if1.add_a), 32'hF);
        cyc = 0;
        while (!if1.out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("n1 latency", 32'(cyc), 32'd1);
        chk("n1 out_sum", 32'(if1.out_sum), 32'hF);
        chk("n1 out_cout", 32'(if1.out_cout), 32'd1);
        if1.out_ready = 1'b1;
        @(negedge clk);
        if1.out_ready = 1'b0;
        chk("n1 in_ready after", 32'(if1.in_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
